// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM stepping MIPS instructions through fetch/decode/execute/memory/writeback
//   Ports: clk, rst_n (async, active low), en (low = stall), memReady (memory done),
//          opcode (IR opcode field), zero (ALU zero flag, consumed by the datapath PC logic);
//          ctrl* datapath strobes and mux selects, ctrlALUOp for ALUCtrl,
//          instrDone (final-state pulse), illegalOp (DECODE pulse on unsupported opcode).
//   Build option: define CTRL_MEM_HANDSHAKE_EN to make FETCH, MEM_RD and MEM_WR wait for memReady.
module multicycle_ctrl #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                memReady,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                ctrlPCWrite,
  output logic                ctrlPCWriteCond,
  output logic                ctrlIorD,
  output logic                ctrlMemRead,
  output logic                ctrlMemWrite,
  output logic                ctrlIRWrite,
  output logic [1:0]          ctrlRegDst,
  output logic [1:0]          ctrlMemToReg,
  output logic                ctrlALUSrcA,
  output logic [1:0]          ctrlALUSrcB,
  output logic [ALUOP_W-1:0]  ctrlALUOp,
  output logic [1:0]          ctrlPCSrc,
  output logic                ctrlRegWrite,
  output logic                instrDone,
  output logic                illegalOp
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADR  = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_ADDI_EX  = 4'd8;
  localparam logic [3:0] S_ADDI_WB  = 4'd9;
  localparam logic [3:0] S_BEQ_EX   = 4'd10;
  localparam logic [3:0] S_J_EX     = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'h2B);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'h02);

  logic [3:0] state_q, state_d;
  logic       mem_ok;
  logic       strobe_en;
  logic       is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_legal;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       alu_src_a, reg_write, done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic       unused_zero;

`ifdef CTRL_MEM_HANDSHAKE_EN
  assign mem_ok = memReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = memReady;
  assign mem_ok = 1'b1;
`endif

  // zero only qualifies the PC load in the datapath; the FSM never branches on it
  assign unused_zero = zero;
  assign strobe_en   = rst_n & en;

  assign is_rtype = opcode == OP_RTYPE;
  assign is_lw    = opcode == OP_LW;
  assign is_sw    = opcode == OP_SW;
  assign is_beq   = opcode == OP_BEQ;
  assign is_addi  = opcode == OP_ADDI;
  assign is_j     = opcode == OP_J;
  assign is_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (en)
      case (state_q)
        S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
        S_DECODE:   state_d = is_rtype ? S_RTYPE_EX :
                              (is_lw | is_sw) ? S_MEM_ADR :
                              is_beq ? S_BEQ_EX :
                              is_addi ? S_ADDI_EX :
                              is_j ? S_J_EX : S_FETCH;
        // opcode is still held in the IR, so LW/SW is re-resolved here
        S_MEM_ADR:  state_d = is_lw ? S_MEM_RD : is_sw ? S_MEM_WR : S_FETCH;
        S_MEM_RD:   state_d = mem_ok ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   state_d = mem_ok ? S_FETCH : S_MEM_WR;
        S_RTYPE_EX: state_d = S_RTYPE_WB;
        S_ADDI_EX:  state_d = S_ADDI_WB;
        default:    state_d = S_FETCH;
      endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !is_legal;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        done       = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = mem_ok;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        done      = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        done          = 1'b1;
      end
      S_J_EX: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  // strobes are gated by rst_n directly so reset kills them without a clock edge
  assign ctrlPCWrite     = pc_write & strobe_en;
  assign ctrlPCWriteCond = pc_write_cond & strobe_en;
  assign ctrlMemWrite    = mem_write & strobe_en;
  assign ctrlIRWrite     = ir_write & strobe_en;
  assign ctrlRegWrite    = reg_write & strobe_en;
  assign instrDone       = done & strobe_en;
  assign illegalOp       = illegal & strobe_en;
  assign ctrlIorD        = iord;
  assign ctrlMemRead     = mem_read;
  assign ctrlRegDst      = reg_dst;
  assign ctrlMemToReg    = mem_to_reg;
  assign ctrlALUSrcA     = alu_src_a;
  assign ctrlALUSrcB     = alu_src_b;
  assign ctrlALUOp       = ALUOP_W'(alu_op);
  assign ctrlPCSrc       = pc_src;
endmodule
